// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: FSM states, opcodes,
// one-hot ALU selects and AC source encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        OPND   = 3'd2,
        MEM    = 3'd3,
        EXEC   = 3'd4,
        ZCAP   = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDAC = 8'h01;
    localparam logic [7:0] OP_STAC = 8'h02;
    localparam logic [7:0] OP_MVAC = 8'h03;
    localparam logic [7:0] OP_MOVR = 8'h04;
    localparam logic [7:0] OP_JUMP = 8'h05;
    localparam logic [7:0] OP_JMPZ = 8'h06;
    localparam logic [7:0] OP_JPNZ = 8'h07;
    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_INAC = 8'h0A;
    localparam logic [7:0] OP_CLAC = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [7:0] ALU_NONE = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_INAC = 8'h04;
    localparam logic [7:0] ALU_CLAC = 8'h08;
    localparam logic [7:0] ALU_AND  = 8'h10;
    localparam logic [7:0] ALU_OR   = 8'h20;
    localparam logic [7:0] ALU_XOR  = 8'h40;
    localparam logic [7:0] ALU_NOT  = 8'h80;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_R   = 2'd2;

    // ALU opcodes occupy 08..0F, so the low three bits pick the select bit.
    function automatic logic [7:0] alu_onehot(input logic [7:0] op);
        logic [7:0] sel;
        sel = ALU_NONE;
        if (op[7:3] == 5'b00001) begin
            sel = ALU_ADD << op[2:0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational classification of the instruction register into the flags
// the control FSM branches on.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic       needs_operand,
    output logic       is_mem,
    output logic       is_jump,
    output logic       is_alu,
    output logic [7:0] alu_sel,
    output logic       halt
);

    assign is_mem        = (ir == OP_LDAC) || (ir == OP_STAC);
    assign is_jump       = (ir == OP_JUMP) || (ir == OP_JMPZ) || (ir == OP_JPNZ);
    assign needs_operand = is_mem || is_jump;
    assign is_alu        = (ir[7:3] == 5'b00001);
    assign alu_sel       = alu_onehot(ir);
    assign halt          = (ir == OP_HALT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for an 8-bit accumulator CPU: sequences fetch,
// operand, memory and execute phases and drives the datapath strobes.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] alu_sel,
    output logic       ac_ld,
    output logic [1:0] ac_src,
    output logic       r_ld,
    output logic [7:0] pc,
    output logic       halted
);

    state_t     state_reg, state_next;
    logic [7:0] pc_reg, pc_next;
    logic [7:0] ir_reg, ir_next;
    logic [7:0] ar_reg, ar_next;
    logic       z_flag_reg, z_flag_next;

    logic       needs_operand;
    logic       is_mem;
    logic       is_jump;
    logic       is_alu;
    logic [7:0] dec_alu_sel;
    logic       is_halt;
    logic       take_jump;

    logic       req_raw, we_raw, ac_ld_raw, r_ld_raw;
    logic [7:0] alu_sel_raw;

    opcode_decode u_decode (
        .ir            (ir_reg),
        .needs_operand (needs_operand),
        .is_mem        (is_mem),
        .is_jump       (is_jump),
        .is_alu        (is_alu),
        .alu_sel       (dec_alu_sel),
        .halt          (is_halt)
    );

    assign take_jump = is_jump &&
                       ((ir_reg == OP_JUMP) ||
                        ((ir_reg == OP_JMPZ) &&  z_flag_reg) ||
                        ((ir_reg == OP_JPNZ) && !z_flag_reg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= FETCH;
            pc_reg     <= 8'h00;
            ir_reg     <= 8'h00;
            ar_reg     <= 8'h00;
            z_flag_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            ar_reg     <= ar_next;
            z_flag_reg <= z_flag_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        ar_next     = ar_reg;
        z_flag_next = z_flag_reg;
        req_raw     = 1'b0;
        we_raw      = 1'b0;
        mem_addr    = pc_reg;
        alu_sel_raw = ALU_NONE;
        ac_ld_raw   = 1'b0;
        ac_src      = SRC_ALU;
        r_ld_raw    = 1'b0;

        unique case (state_reg)
            FETCH: begin
                req_raw = 1'b1;
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_reg + 8'd1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    state_next = HALT;
                end else if (needs_operand) begin
                    state_next = OPND;
                end else begin
                    state_next = EXEC;
                end
            end
            OPND: begin
                req_raw = 1'b1;
                if (mem_ready) begin
                    ar_next = mem_rdata;
                    if (is_mem) begin
                        pc_next    = pc_reg + 8'd1;
                        state_next = MEM;
                    end else begin
                        pc_next    = take_jump ? mem_rdata : pc_reg + 8'd1;
                        state_next = FETCH;
                    end
                end
            end
            MEM: begin
                req_raw  = 1'b1;
                we_raw   = (ir_reg == OP_STAC);
                mem_addr = ar_reg;
                if (mem_ready) begin
                    if (ir_reg == OP_LDAC) begin
                        ac_ld_raw = 1'b1;
                        ac_src    = SRC_MEM;
                    end
                    state_next = FETCH;
                end
            end
            EXEC: begin
                if (is_alu) begin
                    alu_sel_raw = dec_alu_sel;
                    ac_ld_raw   = 1'b1;
                    state_next  = ZCAP;
                end else if (ir_reg == OP_MVAC) begin
                    r_ld_raw   = 1'b1;
                    state_next = FETCH;
                end else if (ir_reg == OP_MOVR) begin
                    ac_ld_raw  = 1'b1;
                    ac_src     = SRC_R;
                    state_next = FETCH;
                end else begin
                    state_next = FETCH;
                end
            end
            ZCAP: begin
                z_flag_next = zero;
                state_next  = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Reset forces FETCH, which would otherwise request address 00 while reset
    // is still high; gate every strobe so an in-flight transfer is abandoned.
    assign mem_req = req_raw     & ~reset;
    assign mem_we  = we_raw      & ~reset;
    assign ac_ld   = ac_ld_raw   & ~reset;
    assign r_ld    = r_ld_raw    & ~reset;
    assign alu_sel = alu_sel_raw & {8{~reset}};

    assign pc     = pc_reg;
    assign halted = (state_reg == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: ISA-level model predicts bus transfers
// and datapath strobes; directed programs pin cycle counts and final state.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       mem_req, mem_we, ac_ld, r_ld, halted;
    logic [7:0] mem_addr, alu_sel, pc;
    logic [1:0] ac_src;

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .zero      (zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .alu_sel   (alu_sel),
        .ac_ld     (ac_ld),
        .ac_src    (ac_src),
        .r_ld      (r_ld),
        .pc        (pc),
        .halted    (halted)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- ISA-level reference model ----------------
    logic [7:0]  mm [256];
    logic [16:0] exp_x[$];   // {we, addr, data}
    logic [11:0] exp_s[$];   // {alu_sel, ac_ld, r_ld, ac_src}
    logic [7:0]  exp_pc;

    function automatic logic [7:0] isa_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h08:   return a + b;
            8'h09:   return a - b;
            8'h0A:   return a + 8'd1;
            8'h0B:   return 8'h00;
            8'h0C:   return a & b;
            8'h0D:   return a | b;
            8'h0E:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic model_run();
        logic [7:0] mpc, a, rr, op, opnd, sel;
        logic       z;
        mpc = 8'h00; a = 8'h00; rr = 8'h00; z = 1'b0;
        exp_x.delete();
        exp_s.delete();
        exp_pc = 8'h00;
        for (int step = 0; step < 300; step++) begin
            op = mm[mpc];
            exp_x.push_back({1'b0, mpc, op});
            mpc = mpc + 8'd1;
            if (op == 8'hFF) begin
                exp_pc = mpc;
                return;
            end
            if (op >= 8'h01 && op <= 8'h07 && op != 8'h03 && op != 8'h04) begin
                opnd = mm[mpc];
                exp_x.push_back({1'b0, mpc, opnd});
                mpc = mpc + 8'd1;
                case (op)
                    8'h01: begin
                        exp_x.push_back({1'b0, opnd, mm[opnd]});
                        a = mm[opnd];
                        exp_s.push_back({8'h00, 1'b1, 1'b0, 2'd1});
                    end
                    8'h02: begin
                        exp_x.push_back({1'b1, opnd, a});
                        mm[opnd] = a;
                    end
                    8'h05: mpc = opnd;
                    8'h06: if (z) mpc = opnd;
                    default: if (!z) mpc = opnd;
                endcase
            end else if (op == 8'h03) begin
                rr = a;
                exp_s.push_back({8'h00, 1'b0, 1'b1, 2'd0});
            end else if (op == 8'h04) begin
                a = rr;
                exp_s.push_back({8'h00, 1'b1, 1'b0, 2'd2});
            end else if (op >= 8'h08 && op <= 8'h0F) begin
                sel = 8'h01 << (op - 8'd8);
                a = isa_alu(op, a, rr);
                z = (a == 8'h00);
                exp_s.push_back({sel, 1'b1, 1'b0, 2'd0});
            end
        end
        exp_pc = mpc;
    endtask

    // Bench-side datapath: applies DUT strobes to AC/R and produces zero.
    function automatic logic [7:0] dp_alu(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h04:   return a + 8'd1;
            8'h08:   return 8'h00;
            8'h10:   return a & b;
            8'h20:   return a | b;
            8'h40:   return a ^ b;
            8'h80:   return ~a;
            default: return a;
        endcase
    endfunction

    logic [7:0] ac = 8'h00, r = 8'h00;
    logic       model_on = 1'b0;
    int         wait_n = 0;
    int         cyc = 0;
    int         halt_cyc = -1, first_wr_cyc = -1, first_ld_cyc = -1;
    int         alu_cyc[$];

    // Memory responder, datapath and per-cycle compare against the model.
    initial begin : compare
        int         wait_left;
        logic       prev_wait;
        logic [7:0] prev_addr, prev_pc, nv;
        logic       prev_we;
        logic [16:0] ax;
        logic [11:0] as;
        wait_left = 0;
        prev_wait = 1'b0;
        prev_addr = 8'h00; prev_pc = 8'h00; prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0;
                mem_ready = 1'b0;
                wait_left = wait_n;
                prev_wait = 1'b0;
                ac = 8'h00; r = 8'h00; zero = 1'b0;
            end else begin
                if (mem_req) begin
                    if (wait_left > 0) begin
                        mem_ready = 1'b0;
                        wait_left--;
                    end else begin
                        mem_ready = 1'b1;
                        wait_left = wait_n;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
                #1;
                if (prev_wait) begin
                    check("hold_req", {31'd0, mem_req}, 32'd1);
                    check("hold_addr", {24'd0, mem_addr}, {24'd0, prev_addr});
                    check("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
                    check("hold_pc", {24'd0, pc}, {24'd0, prev_pc});
                end
                prev_wait = mem_req && !mem_ready;
                prev_addr = mem_addr; prev_we = mem_we; prev_pc = pc;
                if (halted) begin
                    check("halt_quiet", {20'd0, mem_req, ac_ld, r_ld, 1'b0, alu_sel}, 32'd0);
                    if (halt_cyc < 0) halt_cyc = cyc;
                end
                if (mem_req && mem_ready) begin
                    ax = {mem_we, mem_addr, mem_we ? ac : mem_rdata};
                    if (mem_we && first_wr_cyc < 0) first_wr_cyc = cyc;
                    if (model_on) begin
                        if (exp_x.size() == 0) check("xfer_extra", {15'd0, ax}, 32'h1FFFF);
                        else check("xfer", {15'd0, ax}, {15'd0, exp_x.pop_front()});
                    end
                    if (mem_we) mem[mem_addr] = ac;
                end
                if (alu_sel != 8'h00 || ac_ld || r_ld) begin
                    as = {alu_sel, ac_ld, r_ld, ac_ld ? ac_src : 2'd0};
                    if (alu_sel != 8'h00) alu_cyc.push_back(cyc);
                    if (ac_ld && ac_src == 2'd1 && first_ld_cyc < 0) first_ld_cyc = cyc;
                    if (model_on) begin
                        if (exp_s.size() == 0) check("strobe_extra", {20'd0, as}, 32'hFFF);
                        else check("strobe", {20'd0, as}, {20'd0, exp_s.pop_front()});
                    end
                    nv = ac;
                    if (ac_ld) begin
                        case (ac_src)
                            2'd0:    nv = dp_alu(alu_sel, ac, r);
                            2'd1:    nv = mem_rdata;
                            default: nv = r;
                        endcase
                    end
                    if (alu_sel != 8'h00) zero = (dp_alu(alu_sel, ac, r) == 8'h00);
                    if (r_ld) r = ac;
                    ac = nv;
                end
                cyc++;
            end
        end
    end

    task automatic load(input logic [7:0] img[$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        for (int i = 0; i < img.size(); i++) mem[i] = img[i];
    endtask

    task automatic start_reset(input int wn);
        @(negedge clk);
        #3;
        wait_n = wn;
        reset = 1'b1;
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
    endtask

    task automatic run_prog(input string tag, input int wn);
        start_reset(wn);
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        model_run();
        model_on = 1'b1;
        alu_cyc.delete();
        halt_cyc = -1; first_wr_cyc = -1; first_ld_cyc = -1;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 600 && halt_cyc < 0; i++) @(posedge clk);
        if (halt_cyc < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_xq_left"}, exp_x.size(), 32'd0);
        check({tag, "_sq_left"}, exp_s.size(), 32'd0);
        check({tag, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        $display("[TB] program %s wait=%0d: pc=%0h halt_cyc=%0d alu_pulses=%0d", tag, wn, pc, halt_cyc, alu_cyc.size());
    endtask

    initial begin : main
        logic [7:0] img[$];

        // INAC, INAC, HALT at zero wait
        img = '{8'h0A, 8'h0A, 8'hFF};
        load(img);
        run_prog("inac2", 0);
        check("inac2_npulse", alu_cyc.size(), 32'd2);
        if (alu_cyc.size() >= 2) begin
            check("inac2_pulse0", alu_cyc[0], 32'd2);
            check("inac2_pulse1", alu_cyc[1], 32'd6);
        end
        check("inac2_halt_cyc", halt_cyc, 32'd10);
        check("inac2_pc_lit", {24'd0, pc}, 32'h03);

        // LDAC 10, STAC 20, HALT
        img = '{8'h01, 8'h10, 8'h02, 8'h20, 8'hFF};
        load(img);
        mem[8'h10] = 8'h5A;
        run_prog("ldst", 0);
        check("ldst_ld_cyc", first_ld_cyc, 32'd3);
        check("ldst_wr_cyc", first_wr_cyc, 32'd7);
        check("ldst_mem20", {24'd0, mem[8'h20]}, 32'h5A);
        check("ldst_halt_cyc", halt_cyc, 32'd10);

        // CLAC then JMPZ 40 (taken)
        img = '{8'h0B, 8'h06, 8'h40};
        load(img);
        run_prog("jmpz", 0);
        check("jmpz_pc_lit", {24'd0, pc}, 32'h41);
        check("jmpz_halt_cyc", halt_cyc, 32'd9);

        // INAC then JPNZ 40 (taken)
        img = '{8'h0A, 8'h07, 8'h40};
        load(img);
        run_prog("jpnz", 0);
        check("jpnz_pc_lit", {24'd0, pc}, 32'h41);

        // INAC then JMPZ 40 (falls through to 03)
        img = '{8'h0A, 8'h06, 8'h40};
        load(img);
        run_prog("jmpz_nt", 0);
        check("jmpz_nt_pc_lit", {24'd0, pc}, 32'h04);

        // Three wait states on every transfer
        img = '{8'h0A, 8'hFF};
        load(img);
        run_prog("wait3", 3);
        check("wait3_npulse", alu_cyc.size(), 32'd1);
        if (alu_cyc.size() >= 1) check("wait3_pulse0", alu_cyc[0], 32'd5);
        check("wait3_halt_cyc", halt_cyc, 32'd12);

        // PC wrap: JPNZ FE; FE: CLAC; FF: NOP -> wraps to 00; second JPNZ falls through
        img = '{8'h07, 8'hFE, 8'hFF};
        load(img);
        mem[8'hFE] = 8'h0B;
        mem[8'hFF] = 8'h00;
        run_prog("wrap", 0);
        check("wrap_pc_lit", {24'd0, pc}, 32'h03);

        // Mixed ALU/register ops, unknown opcode, final store
        img = '{8'h0A, 8'h03, 8'h0A, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h0E,
                8'h0F, 8'h04, 8'h10, 8'h00, 8'h02, 8'h30, 8'hFF};
        load(img);
        run_prog("alumix", 1);
        check("alumix_mem30", {24'd0, mem[8'h30]}, 32'h01);
        check("alumix_pc_lit", {24'd0, pc}, 32'h0F);

        // Reset during a waiting STAC write
        img = '{8'h0A, 8'h02, 8'h20, 8'hFF};
        load(img);
        mem[8'h20] = 8'h77;
        start_reset(3);
        model_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                #2;
                if (mem_req && mem_we) seen = 1'b1;
            end
            check("midrst_write_seen", {31'd0, seen}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_mem20", {24'd0, mem[8'h20]}, 32'h77);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_next_req", {31'd0, mem_req}, 32'd1);
        check("midrst_next_addr", {24'd0, mem_addr}, 32'h00);
        $display("[TB] program midrst: restart request at %0h", mem_addr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
